// File: rtl/safe_mode_fsm.sv
// safe_mode_fsm: 5-state mode sequencer (IDLE/ARM/RUN/DRAIN/FAULT) with dwell, timeout and drain counters.
// Latency: one cycle from an accepted cmd to the new state/out; all outputs are registered from next state.
// Backpressure: none; cmd is sampled every cycle while cmd_valid is high, and ignored when cmd_valid is low.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   cmd_valid, cmd[2:0] command qualifier and code (0 NOP, 1 ARM, 2 START, 3 STOP, 4 CLEAR, 5..7 illegal)
//   out[OUT_W-1:0]      mode code for the downstream datapath (FAULT drives all ones)
//   state[2:0]          raw state encoding, for debug
//   busy, fault         ARM/RUN/DRAIN indicator, FAULT indicator
//   fault_cause[1:0]    1 illegal cmd, 2 illegal state, 3 state parity error, 0 when not in FAULT
//
// Optional build macro FSM_STATE_PARITY_EN adds an even-parity bit alongside the state register.
// Parameter limits: OUT_W >= 3, ARM_DWELL >= 1, RUN_TIMEOUT >= 2, DRAIN_CYC >= 1.

module safe_mode_fsm #(
    parameter int OUT_W       = 3,
    parameter int ARM_DWELL   = 4,
    parameter int RUN_TIMEOUT = 16,
    parameter int DRAIN_CYC   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    output logic [OUT_W-1:0] out,
    output logic [2:0]       state,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_cause
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    localparam logic [2:0] CMD_ARM   = 3'd1;
    localparam logic [2:0] CMD_START = 3'd2;
    localparam logic [2:0] CMD_STOP  = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_CMD   = 2'd1;
    localparam logic [1:0] CAUSE_STATE = 2'd2;
`ifdef FSM_STATE_PARITY_EN
    localparam logic [1:0] CAUSE_PAR   = 2'd3;
`endif

    // One counter width sized for the largest of the three limits.
    localparam int CNT_MAX_AR = (ARM_DWELL > RUN_TIMEOUT) ? ARM_DWELL : RUN_TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_AR > DRAIN_CYC) ? CNT_MAX_AR : DRAIN_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_SAT  = CNT_W'(ARM_DWELL);
    localparam logic [CNT_W-1:0] DWELL_THR  = CNT_W'(ARM_DWELL - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    logic [2:0]       state_q;
    state_e           state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] drain_q, drain_d;
`ifdef FSM_STATE_PARITY_EN
    logic             par_q, par_d;
    logic             par_err;
`endif

    logic cmd_illegal;
    logic cmd_arm, cmd_start, cmd_stop, cmd_clear;

    assign cmd_illegal = cmd_valid && (cmd >= 3'd5);
    assign cmd_arm     = cmd_valid && (cmd == CMD_ARM);
    assign cmd_start   = cmd_valid && (cmd == CMD_START);
    assign cmd_stop    = cmd_valid && (cmd == CMD_STOP);
    assign cmd_clear   = cmd_valid && (cmd == CMD_CLEAR);

`ifdef FSM_STATE_PARITY_EN
    // Even parity: stored bit must equal the XOR of the state bits.
    assign par_err = par_q != (^state_q);
`endif

    always_comb begin
        state_d = S_FAULT;
        cause_d = cause_q;

        // Illegal commands win over everything except reset, but cannot
        // overwrite the cause once already in FAULT.
        if (cmd_illegal && (state_q != S_FAULT)) begin
            state_d = S_FAULT;
            cause_d = CAUSE_CMD;
        end
`ifdef FSM_STATE_PARITY_EN
        else if (par_err) begin
            state_d = S_FAULT;
            cause_d = CAUSE_PAR;
        end
`endif
        else begin
            case (state_q)
                S_IDLE:  state_d = cmd_arm ? S_ARM : S_IDLE;
                S_ARM: begin
                    if (cmd_stop)
                        state_d = S_IDLE;
                    else if (cmd_start && (dwell_q >= DWELL_THR))
                        state_d = S_RUN;
                    else
                        state_d = S_ARM;
                end
                // STOP and timeout on the same cycle both land in DRAIN.
                S_RUN:   state_d = (cmd_stop || (run_q == RUN_LAST)) ? S_DRAIN : S_RUN;
                S_DRAIN: state_d = (drain_q == DRAIN_LAST) ? S_IDLE : S_DRAIN;
                S_FAULT: state_d = cmd_clear ? S_IDLE : S_FAULT;
                default: begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_STATE;
                end
            endcase
        end

        // Cause is only meaningful while in FAULT; leaving FAULT clears it.
        if (state_d != S_FAULT)
            cause_d = CAUSE_NONE;

        // Counters run only while staying in their own state and restart
        // from zero on every entry.
        dwell_d = '0;
        run_d   = '0;
        drain_d = '0;
        if ((state_q == S_ARM) && (state_d == S_ARM))
            dwell_d = (dwell_q >= DWELL_SAT) ? dwell_q : dwell_q + 1'b1;
        if ((state_q == S_RUN) && (state_d == S_RUN))
            run_d = run_q + 1'b1;
        if ((state_q == S_DRAIN) && (state_d == S_DRAIN))
            drain_d = drain_q + 1'b1;

        out_d   = (state_d == S_FAULT) ? {OUT_W{1'b1}} : OUT_W'(state_d);
        busy_d  = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
        fault_d = (state_d == S_FAULT);
`ifdef FSM_STATE_PARITY_EN
        par_d   = ^state_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            dwell_q <= '0;
            run_q   <= '0;
            drain_q <= '0;
`ifdef FSM_STATE_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            dwell_q <= dwell_d;
            run_q   <= run_d;
            drain_q <= drain_d;
`ifdef FSM_STATE_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out         = out_q;
    assign state       = state_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_safe_mode_fsm.sv
// tb_safe_mode_fsm: directed stimulus for safe_mode_fsm against a mode/age model, plus literal spot checks.
// Latency: expects outputs one edge after each sampled command.
// Backpressure: none; one command is applied per cycle.

module tb_safe_mode_fsm;

    localparam int OUT_W       = 3;
    localparam int ARM_DWELL   = 4;
    localparam int RUN_TIMEOUT = 16;
    localparam int DRAIN_CYC   = 3;

    localparam logic [2:0] NOP = 3'd0, ARM = 3'd1, START = 3'd2, STOP = 3'd3, CLEAR = 3'd4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [OUT_W-1:0] out;
    logic [2:0]       state;
    logic             busy;
    logic             fault;
    logic [1:0]       fault_cause;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    // Model: current mode (0 idle .. 4 fault), cycles already spent in it, and cause.
    int m_mode  = 0;
    int m_age   = 0;
    int m_cause = 0;
    bit m_bad_state = 1'b0;
    bit m_bad_par   = 1'b0;

    safe_mode_fsm #(
        .OUT_W(OUT_W), .ARM_DWELL(ARM_DWELL), .RUN_TIMEOUT(RUN_TIMEOUT), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .out(out), .state(state), .busy(busy), .fault(fault), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [2:0] c);
        int nm;
        int nc;
        nm = m_mode;
        nc = m_cause;
        if (v && (c >= 3'd5) && (m_mode != 4)) begin
            nm = 4; nc = 1;
        end else if (m_bad_par) begin
            nm = 4; nc = 3;
        end else if (m_bad_state) begin
            nm = 4; nc = 2;
        end else begin
            case (m_mode)
                0: if (v && c == ARM) nm = 1;
                1: begin
                    if (v && c == STOP) nm = 0;
                    else if (v && c == START && m_age >= ARM_DWELL - 1) nm = 2;
                end
                2: if ((v && c == STOP) || m_age == RUN_TIMEOUT - 1) nm = 3;
                3: if (m_age == DRAIN_CYC - 1) nm = 0;
                default: if (v && c == CLEAR) nm = 0;
            endcase
        end
        if (nm != 4) nc = 0;
        m_age   = (nm == m_mode) ? m_age + 1 : 0;
        m_mode  = nm;
        m_cause = nc;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_age = 0; m_cause = 0;
            end else begin
                model_edge(cmd_valid, cmd);
            end
            m_bad_state = 1'b0;
            m_bad_par   = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #2;
            if (!done) begin
                check("model.state", 32'(state), 32'(m_mode));
                check("model.out", 32'(out), (m_mode == 4) ? 32'((1 << OUT_W) - 1) : 32'(m_mode));
                check("model.busy", 32'(busy), 32'(m_mode >= 1 && m_mode <= 3));
                check("model.fault", 32'(fault), 32'(m_mode == 4));
                check("model.cause", 32'(fault_cause), 32'(m_cause));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick(input logic v, input logic [2:0] c);
        @(negedge clk);
        cmd_valid = v;
        cmd       = c;
        @(posedge clk);
        #3;
    endtask

    task automatic lit(input string name, input int st, input int o, input int cause);
        check({name, ".state"}, 32'(state), 32'(st));
        check({name, ".out"}, 32'(out), 32'(o));
        check({name, ".cause"}, 32'(fault_cause), 32'(cause));
    endtask

    task automatic go_run();
        tick(1'b1, ARM);
        repeat (3) tick(1'b0, NOP);
        tick(1'b1, START);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = NOP;

        // Reset then idle.
        repeat (3) begin
            @(posedge clk);
            #3;
            lit("rst_hold", 0, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            tick(1'b0, NOP);
            lit("idle", 0, 0, 0);
            check("idle.busy", 32'(busy), 32'd0);
            check("idle.fault", 32'(fault), 32'd0);
        end

        // Normal sequence.
        tick(1'b1, ARM);
        lit("arm_entry", 1, 1, 0);
        check("arm.busy", 32'(busy), 32'd1);
        tick(1'b0, NOP);
        tick(1'b0, NOP);
        tick(1'b1, START);
        lit("early_start", 1, 1, 0);
        tick(1'b1, START);
        lit("run_entry", 2, 2, 0);
        repeat (4) tick(1'b0, NOP);
        tick(1'b1, STOP);
        lit("drain_1", 3, 3, 0);
        tick(1'b1, START);
        lit("drain_2", 3, 3, 0);
        tick(1'b0, NOP);
        lit("drain_3", 3, 3, 0);
        tick(1'b0, NOP);
        lit("drain_done", 0, 0, 0);
        check("drain_done.busy", 32'(busy), 32'd0);

        // Timeout: 16 RUN cycles with no command.
        go_run();
        lit("to_run", 2, 2, 0);
        for (int i = 1; i < RUN_TIMEOUT; i++) begin
            tick(1'b0, NOP);
            check("to_still_run", 32'(state), 32'd2);
        end
        tick(1'b0, NOP);
        lit("to_drain", 3, 3, 0);
        repeat (3) tick(1'b0, NOP);
        lit("to_idle", 0, 0, 0);

        // Illegal command in RUN.
        go_run();
        tick(1'b1, 3'd6);
        lit("illcmd", 4, 7, 1);
        check("illcmd.fault", 32'(fault), 32'd1);
        check("illcmd.busy", 32'(busy), 32'd0);
        tick(1'b1, START);
        lit("fault_start", 4, 7, 1);
        tick(1'b1, 3'd7);
        lit("fault_illcmd", 4, 7, 1);
        tick(1'b1, CLEAR);
        lit("clear", 0, 0, 0);

        // Illegal state injected into the state register while idle.
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = NOP;
        #1;
        dut.state_q <= 3'd6;
        m_bad_state = 1'b1;
        @(posedge clk);
        #3;
        lit("illstate", 4, 7, 2);
        tick(1'b1, CLEAR);
        lit("illstate_clear", 0, 0, 0);

`ifdef FSM_STATE_PARITY_EN
        go_run();
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = NOP;
        #1;
        dut.par_q <= ~dut.par_q;
        m_bad_par = 1'b1;
        @(posedge clk);
        #3;
        lit("parity", 4, 7, 3);
        tick(1'b1, CLEAR);
        lit("parity_clear", 0, 0, 0);
`endif

        // Async reset in the middle of RUN.
        go_run();
        tick(1'b0, NOP);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 0, 0);
        check("async_rst.busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, ARM);
        lit("post_rst_arm", 1, 1, 0);
        check("post_rst_arm.busy", 32'(busy), 32'd1);
        tick(1'b1, STOP);
        lit("post_rst_stop", 0, 0, 0);

        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
